// File: rtl/nn_param_loader_if.sv
// Parameter word stream into the loader: one signed word per valid/ready handshake.
// Latency: n/a (signal bundle only).
// Backpressure: the source holds s_data/s_valid until it sees s_ready high at a clock edge.
//
// Ports:
//   s_data  - signed parameter word
//   s_valid - s_data is valid
//   s_ready - loader accepts a word this cycle
interface nn_param_loader_if #(
   parameter int WIDTH = 16
);
   logic signed [WIDTH-1:0] s_data;
   logic                    s_valid;
   logic                    s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/nn_param_loader.sv
// Double-buffered network parameter loader: a stream fills a shadow bank, and a commit copies it to the active bank.
// Latency: after start, NPARAM accepted words, then one COMMIT cycle; done pulses the cycle after the commit edge.
// Backpressure: s_ready is high only in LOAD, and stalls on s_valid=0. start in LOAD restarts the sequence; start in COMMIT is ignored.
//
// Ports:
//   i_clk, i_rst       - clock and asynchronous active-low reset
//   i_start            - single-cycle request to begin a load
//   s_if               - word stream (slave side)
//   o_params           - active bank; word i at [i*WIDTH +: WIDTH]
//   o_params_valid     - at least one load has been committed since reset
//   o_busy             - LOAD or COMMIT in progress
//   o_done             - one-cycle commit pulse
//   o_err              - sticky: a load was restarted by start
//   o_word_cnt         - words accepted in the current sequence
module nn_param_loader #(
   parameter int WIDTH  = 16,
   parameter int FRAC   = 8,
   parameter int NPARAM = 62
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   nn_param_loader_if.slave        s_if,
   output logic [NPARAM*WIDTH-1:0] o_params,
   output logic                    o_params_valid,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err,
   output logic [5:0]              o_word_cnt
);

   // FRAC only documents the fixed-point format; reject settings that cannot be a valid format.
   generate
      if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
         $error("nn_param_loader: FRAC must lie in [0, WIDTH)");
      end
      if (NPARAM < 1 || NPARAM > 63) begin : g_bad_nparam
         $error("nn_param_loader: NPARAM must fit the 6-bit word counter");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shadow [NPARAM];
   logic [WIDTH-1:0] r_active [NPARAM];
   logic [5:0]       r_word_cnt;
   logic             r_s_ready;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             r_params_valid;

   logic             w_beat;
   logic             w_last;

   // A beat that coincides with a restart is dropped, so start takes priority here.
   assign w_beat = s_if.s_valid & r_s_ready & ~i_start;
   assign w_last = (r_word_cnt == 6'(NPARAM - 1));

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state        <= ST_IDLE;
         r_word_cnt     <= '0;
         r_s_ready      <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_params_valid <= 1'b0;
         for (int i = 0; i < NPARAM; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state    <= ST_LOAD;
                  r_word_cnt <= '0;
                  r_err      <= 1'b0;
                  r_s_ready  <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (i_start) begin
                  r_word_cnt <= '0;
                  r_err      <= 1'b1;
               end else if (w_beat) begin
                  r_shadow[r_word_cnt] <= s_if.s_data;
                  r_word_cnt           <= r_word_cnt + 6'd1;
                  if (w_last) begin
                     r_state   <= ST_COMMIT;
                     r_s_ready <= 1'b0;
                  end
               end
            end
            ST_COMMIT: begin
               // Only edge on which the active bank changes; start is ignored here.
               r_active       <= r_shadow;
               r_params_valid <= 1'b1;
               r_done         <= 1'b1;
               r_busy         <= 1'b0;
               r_state        <= ST_IDLE;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_s_ready <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   generate
      for (genvar g = 0; g < NPARAM; g++) begin : g_pack
         assign o_params[g*WIDTH +: WIDTH] = r_active[g];
      end
   endgenerate

   assign s_if.s_ready   = r_s_ready;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_err          = r_err;
   assign o_params_valid = r_params_valid;
   assign o_word_cnt     = r_word_cnt;

endmodule

// File: tb/tb_nn_param_loader.sv
// Bench for nn_param_loader: per-cycle reference model plus directed tables and sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_nn_param_loader;
   localparam int W  = 16;
   localparam int NP = 62;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [NP*W-1:0] params;
   logic            params_valid;
   logic            busy;
   logic            done;
   logic            err;
   logic [5:0]      word_cnt;

   nn_param_loader_if #(.WIDTH(W)) bus ();

   nn_param_loader #(.WIDTH(W), .FRAC(8), .NPARAM(NP)) dut (
      .i_clk         (clk),
      .i_rst         (rst_n),
      .i_start       (start),
      .s_if          (bus.slave),
      .o_params      (params),
      .o_params_valid(params_valid),
      .o_busy        (busy),
      .o_done        (done),
      .o_err         (err),
      .o_word_cnt    (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_done = 0;
   int last_done_cyc = -1;

   // Reference model: transaction-level view of a load.
   int          m_phase;      // 0 idle, 1 collecting words, 2 commit pending
   logic [15:0] m_q[$];       // words accepted in the current sequence
   logic [15:0] m_act[NP];
   logic        m_pvalid, m_err, m_done;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void model_reset();
      m_phase  = 0;
      m_q.delete();
      m_pvalid = 1'b0;
      m_err    = 1'b0;
      m_done   = 1'b0;
      for (int i = 0; i < NP; i++) m_act[i] = '0;
   endfunction

   // Apply the loader rules for the inputs currently present, ahead of the edge.
   function automatic void model_update();
      m_done = 1'b0;
      case (m_phase)
         0: if (start) begin
               m_phase = 1;
               m_q.delete();
               m_err = 1'b0;
            end
         1: if (start) begin
               m_q.delete();
               m_err = 1'b1;
            end else if (bus.s_valid) begin
               m_q.push_back(bus.s_data);
               if (m_q.size() == NP) m_phase = 2;
            end
         default: begin
            for (int i = 0; i < NP; i++) m_act[i] = m_q[i];
            m_pvalid = 1'b1;
            m_done   = 1'b1;
            m_phase  = 0;
         end
      endcase
   endfunction

   function automatic void check_all(input string tag);
      logic [NP*W-1:0] exp_p;
      for (int i = 0; i < NP; i++) exp_p[i*W +: W] = m_act[i];
      chk({tag, ".s_ready"}, 64'(bus.s_ready), 64'(m_phase == 1));
      chk({tag, ".busy"}, 64'(busy), 64'(m_phase != 0));
      chk({tag, ".done"}, 64'(done), 64'(m_done));
      chk({tag, ".err"}, 64'(err), 64'(m_err));
      chk({tag, ".params_valid"}, 64'(params_valid), 64'(m_pvalid));
      chk({tag, ".word_cnt"}, 64'(word_cnt), 64'(m_q.size()));
      n_chk++;
      if (params !== exp_p) begin
         n_err++;
         $display("FAIL %s.params: got %0h expected %0h (cycle %0d)", tag, params, exp_p, cyc);
      end
   endfunction

   task automatic drive(input logic s, input logic v, input logic [15:0] d);
      start       = s;
      bus.s_valid = v;
      bus.s_data  = d;
   endtask

   task automatic step(input string tag);
      model_update();
      @(posedge clk);
      cyc++;
      #1;
      if (done === 1'b1) begin
         n_done++;
         last_done_cyc = cyc;
      end
      check_all(tag);
   endtask

   // Called at least 1ns after an edge: asserts reset between edges and checks it acts at once.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_now");
      @(posedge clk);
      cyc++;
      #1;
      check_all("rst_hold");
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        start;
      logic        valid;
      logic [15:0] data;
      logic        rdy;
      logic        busy;
      logic [5:0]  cnt;
      logic        err;
      logic        done;
   } vec_t;

   vec_t tbl[8];

   int t0, lat_a, lat_b, k;
   logic [NP*W-1:0] snap;

   initial begin
      tbl[0] = '{start:0, valid:1, data:16'h1234, rdy:0, busy:0, cnt:0, err:0, done:0};
      tbl[1] = '{start:1, valid:1, data:16'h1234, rdy:1, busy:1, cnt:0, err:0, done:0};
      tbl[2] = '{start:0, valid:1, data:16'h0011, rdy:1, busy:1, cnt:1, err:0, done:0};
      tbl[3] = '{start:0, valid:0, data:16'h0022, rdy:1, busy:1, cnt:1, err:0, done:0};
      tbl[4] = '{start:0, valid:1, data:16'h0033, rdy:1, busy:1, cnt:2, err:0, done:0};
      tbl[5] = '{start:1, valid:1, data:16'h0044, rdy:1, busy:1, cnt:0, err:1, done:0};
      tbl[6] = '{start:0, valid:1, data:16'h0055, rdy:1, busy:1, cnt:1, err:1, done:0};
      tbl[7] = '{start:0, valid:0, data:16'h0066, rdy:1, busy:1, cnt:1, err:1, done:0};

      model_reset();
      rst_n = 1'b0;
      drive(0, 0, 16'h0);
      #3;
      check_all("reset_state");
      @(posedge clk);
      cyc++;
      #1;
      rst_n = 1'b1;

      // s_valid in IDLE without start stores nothing.
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 16'h1234);
         step("idle_valid");
      end
      chk("idle.word_cnt", 64'(word_cnt), 64'd0);
      chk("idle.params_zero", 64'(params == '0), 64'd1);
      chk("idle.no_done", 64'(n_done), 64'd0);

      // Directed vectors: restart in LOAD, stall, discarded beat.
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].start, tbl[i].valid, tbl[i].data);
         step("tbl");
         chk($sformatf("tbl%0d.rdy", i), 64'(bus.s_ready), 64'(tbl[i].rdy));
         chk($sformatf("tbl%0d.busy", i), 64'(busy), 64'(tbl[i].busy));
         chk($sformatf("tbl%0d.cnt", i), 64'(word_cnt), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d.err", i), 64'(err), 64'(tbl[i].err));
         chk($sformatf("tbl%0d.done", i), 64'(done), 64'(tbl[i].done));
      end

      // Back-to-back load of 1..62; start held during COMMIT must be ignored.
      do_reset();
      n_done = 0;
      last_done_cyc = -1;
      drive(1, 0, 16'h0);
      step("a_start");
      t0 = cyc;
      for (int i = 0; i < NP; i++) begin
         drive(0, 1, 16'(i + 1));
         step("a_word");
      end
      drive(1, 0, 16'h0);
      step("a_commit");
      drive(0, 0, 16'h0);
      for (int i = 0; i < 3; i++) step("a_after");
      lat_a = (last_done_cyc < 0) ? -1 : last_done_cyc - t0;
      chk("a.done_latency", 64'(lat_a), 64'(NP + 1));
      chk("a.done_count", 64'(n_done), 64'd1);
      chk("a.params_valid", 64'(params_valid), 64'd1);
      chk("a.word_cnt", 64'(word_cnt), 64'(NP));
      chk("a.busy_after", 64'(busy), 64'd0);
      for (int i = 0; i < NP; i++) chk($sformatf("a.param%0d", i), 64'(params[i*W +: W]), 64'(i + 1));

      // Same stream with s_valid toggling every other cycle.
      n_done = 0;
      last_done_cyc = -1;
      drive(1, 0, 16'h0);
      step("b_start");
      t0 = cyc;
      k = 0;
      for (int j = 1; j < 400 && k < NP; j++) begin
         if (j % 2 == 1) begin
            drive(0, 1, 16'(k + 1));
            k++;
         end else begin
            drive(0, 0, 16'hdead);
         end
         step("b_word");
      end
      drive(0, 0, 16'h0);
      for (int i = 0; i < 3; i++) step("b_after");
      lat_b = (last_done_cyc < 0) ? -1 : last_done_cyc - t0;
      chk("b.latency_delta", 64'(lat_b - lat_a), 64'd61);
      chk("b.done_count", 64'(n_done), 64'd1);
      for (int i = 0; i < NP; i++) chk($sformatf("b.param%0d", i), 64'(params[i*W +: W]), 64'(i + 1));

      // Partial second load never reaches params.
      drive(1, 0, 16'h0);
      step("c_start");
      for (int i = 0; i < 30; i++) begin
         drive(0, 1, 16'h7fff);
         step("c_word");
      end
      drive(0, 0, 16'h7fff);
      for (int i = 0; i < 4; i++) step("c_stall");
      chk("c.busy", 64'(busy), 64'd1);
      chk("c.word_cnt", 64'(word_cnt), 64'd30);
      for (int i = 0; i < NP; i += 7) chk($sformatf("c.param%0d", i), 64'(params[i*W +: W]), 64'(i + 1));

      // Restart at word 20, then a full load of 0x8000.
      do_reset();
      n_done = 0;
      drive(1, 0, 16'h0);
      step("d_start");
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 16'h1111);
         step("d_word");
      end
      drive(1, 1, 16'h1111);
      step("d_restart");
      for (int i = 0; i < NP; i++) begin
         drive(0, 1, 16'h8000);
         step("d_full");
      end
      drive(0, 0, 16'h0);
      for (int i = 0; i < 3; i++) step("d_after");
      chk("d.err", 64'(err), 64'd1);
      chk("d.done_count", 64'(n_done), 64'd1);
      for (int i = 0; i < NP; i++) chk($sformatf("d.param%0d", i), 64'(params[i*W +: W]), 64'h8000);

      // Reset at word 40 of a load: everything clears, no commit follows.
      drive(1, 0, 16'h0);
      step("e_start");
      for (int i = 0; i < 40; i++) begin
         drive(0, 1, 16'h5555);
         step("e_word");
      end
      n_done = 0;
      do_reset();
      chk("e.params_zero", 64'(params == '0), 64'd1);
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 16'h5555);
         step("e_hold");
      end
      chk("e.s_ready", 64'(bus.s_ready), 64'd0);
      chk("e.word_cnt", 64'(word_cnt), 64'd0);
      chk("e.params_valid", 64'(params_valid), 64'd0);
      chk("e.no_done", 64'(n_done), 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 799) == 0) begin
            do_reset();
         end else begin
            drive((m_phase == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 9) < 7), 16'($urandom));
            step("rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
